// File: rtl/j_pipe.sv
// Elastic DEPTH-stage valid/ready pipeline applying a per-beat mask op (pass/OR/AND/XOR MASK) on entry.
// Latency: beat accepted at edge N is presented after edge N+DEPTH-1; 1 beat/cycle sustained.
// Backpressure: bubbles collapse toward the head; in_ready drops combinationally only when all stages are full and out_ready=0 (or flush).
module j_pipe #(
    parameter int unsigned          WIDTH = 8,
    parameter int unsigned          DEPTH = 2,
    parameter logic [WIDTH-1:0]     MASK  = WIDTH'(8'h33)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [1:0]                   in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  beat_count
);

    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_dat [DEPTH];
    logic [15:0]      r_beat_count;

    logic [DEPTH-1:0] w_load;
    logic [WIDTH-1:0] w_f;
    logic             w_accept;
    logic             w_xfer;
    logic [OW-1:0]    w_occ;

    // Stage i may load if the head drains this cycle or any stage at or after i is empty,
    // which is the unrolled form of the chained load rule without a combinational self-loop.
    always_comb begin
        w_load = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_load[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!r_vld[j]) begin
                    w_load[i] = 1'b1;
                end
            end
        end
    end

    // Mask operation selected by the mode sampled alongside the incoming beat.
    always_comb begin
        w_f = in_data;
        case (in_mode)
            2'b00:   w_f = in_data;
            2'b01:   w_f = in_data | MASK;
            2'b10:   w_f = in_data & MASK;
            default: w_f = in_data ^ MASK;
        endcase
    end

    assign in_ready  = w_load[0] && !flush;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_vld[DEPTH-1];
    assign out_data  = r_dat[DEPTH-1];
    assign w_xfer    = r_vld[DEPTH-1] && out_ready;

    // Valid bits shift forward on load; reset and flush both empty the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else if (flush) begin
            r_vld <= '0;
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= w_accept;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
        end
    end

    // Data follows the same load enables; contents of empty stages are don't-care so no reset.
    always_ff @(posedge clk) begin
        if (w_load[0]) begin
            r_dat[0] <= w_f;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (w_load[i]) begin
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    // Delivered-beat counter; a transfer in a flush cycle still counts, reset wins over all.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_count <= 16'h0000;
        end else if (w_xfer) begin
            r_beat_count <= r_beat_count + 16'h0001;
        end
    end

    // Occupancy is the popcount of the stage valid bits.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OW'(r_vld[i]);
        end
    end

    assign occupancy  = w_occ;
    assign beat_count = r_beat_count;

endmodule

// File: tb/tb_j_pipe.sv
// Bench for j_pipe: default 8-bit/2-stage instance plus a 16-bit/5-stage instance for wrap and throughput.
// Scoreboard queues hold expected beats pushed on accept and popped on output transfer.
// Hand-written sequences cover latency, backpressure, flush and reset corners.
module tb_j_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst, in_valid, in_ready, out_valid, out_ready, flush;
    logic [7:0]  in_data, out_data;
    logic [1:0]  in_mode, occupancy;
    logic [15:0] beat_count;

    // WIDTH=16, DEPTH=5, MASK=16'h00FF instance
    logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [15:0] b_in_data, b_out_data, b_beat_count;
    logic [1:0]  b_in_mode;
    logic [2:0]  b_occupancy;

    j_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .flush(flush),
        .occupancy(occupancy), .beat_count(beat_count)
    );

    j_pipe #(.WIDTH(16), .DEPTH(5), .MASK(16'h00FF)) u_big (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_mode(b_in_mode), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .flush(b_flush),
        .occupancy(b_occupancy), .beat_count(b_beat_count)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  sq[$];
    logic [15:0] bq[$];
    int          b_tx = 0;
    int          cyc_n = 0;
    int          b_first_tx = -1;
    int          b_last_tx = -1;
    bit          b_tx_now;

    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fm(input logic [7:0] d, input logic [1:0] m);
        case (m)
            2'b00:   return d;
            2'b01:   return d | 8'h33;
            2'b10:   return d & 8'h33;
            default: return d ^ 8'h33;
        endcase
    endfunction

    // One clock: sample handshakes just before the edge, update scoreboards, advance past the edge.
    task automatic cyc();
        logic [7:0]  e8;
        logic [15:0] e16;
        #1;
        if (rst) begin
            sq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    e8 = sq.pop_front();
                    chk("sb_data", out_data, e8);
                end
            end
            if (flush) sq.delete();
            else if (in_valid && in_ready) sq.push_back(fm(in_data, in_mode));
        end
        b_tx_now = 1'b0;
        if (b_rst) begin
            bq.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                if (bq.size() == 0) chk("big_sb_underflow", 32'd1, 32'd0);
                else begin
                    e16 = bq.pop_front();
                    chk("big_sb_data", b_out_data, e16);
                end
                b_tx++;
                b_tx_now = 1'b1;
                if (b_first_tx < 0) b_first_tx = cyc_n;
                b_last_tx = cyc_n;
            end
            if (b_in_valid && b_in_ready) bq.push_back(b_in_data ^ 16'h00FF);
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (b_tx_now && (b_tx == 65535 || b_tx == 65536))
            chk("big_wrap_count", b_beat_count, b_tx[15:0]);
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{d: 8'hAA, m: 2'b00, exp: 8'hAA};
        tbl[1] = '{d: 8'hF0, m: 2'b10, exp: 8'h30};
        tbl[2] = '{d: 8'hFF, m: 2'b11, exp: 8'hCC};
        tbl[3] = '{d: 8'h0C, m: 2'b01, exp: 8'h3F};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0; flush = 1'b0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 2'b11; b_out_ready = 1'b0; b_flush = 1'b0;
        cyc();
        rst = 1'b0; b_rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_beat_count", beat_count, 0);

        // Empty pipe: toggling out_ready changes nothing
        out_ready = 1'b1; cyc(); out_ready = 1'b0; cyc();
        chk("empty_occ", occupancy, 0);
        chk("empty_count", beat_count, 0);

        // Single beat latency, mode 01
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h40; in_mode = 2'b01;
        cyc();
        in_valid = 1'b0;
        chk("lat_occ1", occupancy, 1);
        chk("lat_not_yet", out_valid, 0);
        cyc();
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 8'h73);
        chk("lat_count0", beat_count, 0);
        cyc();
        chk("lat_count1", beat_count, 1);
        chk("lat_drained", out_valid, 0);

        // Back-to-back mode switching from the vector table
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; in_data = tbl[i].d; in_mode = tbl[i].m;
            end else begin
                in_valid = 1'b0;
            end
            cyc();
            if (i >= 1) begin
                chk("tbl_valid", out_valid, 1);
                chk("tbl_data", out_data, tbl[i-1].exp);
            end
        end
        cyc();
        chk("tbl_count", beat_count, 5);

        // Backpressure: 3 offered, 2 accepted, then drained in order
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00;
        in_data = 8'h11; cyc();
        in_data = 8'h22; cyc();
        in_data = 8'h33;
        #1;
        chk("bp_in_ready0", in_ready, 0);
        chk("bp_occ2", occupancy, 2);
        chk("bp_head", out_data, 8'h11);
        cyc();
        chk("bp_still_full", occupancy, 2);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", in_ready, 1);
        cyc();
        chk("bp_occ_same", occupancy, 2);
        in_valid = 1'b0;
        cyc(); cyc();
        chk("bp_drained", occupancy, 0);
        chk("bp_count", beat_count, 8);

        // Flush with two beats held
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h55; cyc();
        in_data = 8'h66; cyc();
        chk("fl_occ2", occupancy, 2);
        flush = 1'b1; in_data = 8'h77;
        #1;
        chk("fl_in_ready", in_ready, 0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ0", occupancy, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_count", beat_count, 8);
        out_ready = 1'b1; cyc(); cyc(); cyc();
        chk("fl_nothing_left", occupancy, 0);

        // Reset dominates a transfer and flush in the same cycle
        in_valid = 1'b1; in_data = 8'h99; in_mode = 2'b11;
        cyc();
        in_valid = 1'b0;
        cyc();
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
        #1;
        chk("rs_xfer_pending", out_valid, 1);
        cyc();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("rs_in_ready", in_ready, 1);
        chk("rs_out_valid", out_valid, 0);
        chk("rs_occ", occupancy, 0);
        chk("rs_count", beat_count, 0);

        // Wide/deep instance: 70000 continuous XOR beats
        b_out_ready = 1'b1; b_in_mode = 2'b11;
        for (int n = 0; n < 70000; n++) begin
            b_in_valid = 1'b1; b_in_data = n[15:0];
            cyc();
            if (n < 4) chk("big_lat_early", b_out_valid, 0);
            if (n == 4) begin
                chk("big_lat_valid", b_out_valid, 1);
                chk("big_lat_data", b_out_data, 16'h00FF);
            end
        end
        b_in_valid = 1'b0;
        for (int k = 0; k < 8; k++) cyc();
        chk("big_tx_total", b_tx, 70000);
        chk("big_throughput", b_last_tx - b_first_tx, 69999);
        chk("big_wrap_final", b_beat_count, 16'd4464);
        chk("big_empty", b_occupancy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
